// File: rtl/hangman_game_ctrl_if.sv
// Bus bundle between the hangman game controller and its word generator, letter selector and text renderer.
// The controller drives the master side; the surrounding circuit sits on the slave side.
interface hangman_game_ctrl_if #(
  parameter int WORD_LEN = 7
);
  logic                    restart;
  logic [7*WORD_LEN-1:0]   word_in;
  logic                    word_load;
  logic                    guess_valid;
  logic [6:0]              guess_char;
  logic [7*WORD_LEN-1:0]   disp_word;
  logic [WORD_LEN-1:0]     reveal_mask;
  logic [3:0]              wrong_cnt;
  logic                    hit;
  logic                    miss;
  logic                    dup_guess;
  logic                    win;
  logic                    lose;
  logic                    busy;

  modport master (
    input  restart, word_in, guess_valid, guess_char,
    output word_load, disp_word, reveal_mask, wrong_cnt,
           hit, miss, dup_guess, win, lose, busy
  );

  modport slave (
    output restart, word_in, guess_valid, guess_char,
    input  word_load, disp_word, reveal_mask, wrong_cnt,
           hit, miss, dup_guess, win, lose, busy
  );
endinterface

// File: rtl/hangman_game_ctrl.sv
// Hangman game sequencer: fetches a word, scores letter guesses and drives the masked display word.
// Build option: define DUP_PENALTY_EN to count repeated guesses as misses.
module hangman_game_ctrl #(
  parameter int         WORD_LEN   = 7,
  parameter int         MAX_WRONG  = 6,
  parameter logic [6:0] BLANK_CHAR = 7'h5F
) (
  input  logic               clk,
  input  logic               reset,
  hangman_game_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_LATCH, S_PLAY, S_CHECK, S_EVAL, S_WIN, S_LOSE
  } state_t;

  localparam logic [3:0] MAX_WRONG_C = 4'(MAX_WRONG);

  state_t                state_reg, state_next;
  logic [7*WORD_LEN-1:0] word_reg, word_next;
  logic [WORD_LEN-1:0]   mask_reg, mask_next;
  logic [3:0]            wrong_reg, wrong_next;
  logic [25:0]           guessed_reg, guessed_next;
  logic [6:0]            guess_reg, guess_next;
  logic                  hit_reg, hit_next;
  logic                  miss_reg, miss_next;
  logic                  dup_reg, dup_next;
  logic [7*WORD_LEN-1:0] disp_reg, disp_next;

  logic [6:0]            folded;
  logic                  folded_ok;
  logic [4:0]            guess_idx;
  logic [WORD_LEN-1:0]   match_vec;
  logic [WORD_LEN-1:0]   latch_unused;
  logic                  show_all;
  logic [3:0]            wrong_inc;

  assign folded    = (bus.guess_char >= 7'h61 && bus.guess_char <= 7'h7A) ?
                     bus.guess_char - 7'h20 : bus.guess_char;
  assign folded_ok = (folded >= 7'h41) && (folded <= 7'h5A);
  assign guess_idx = 5'(guess_reg - 7'h41);
  assign show_all  = (state_reg == S_WIN) || (state_reg == S_LOSE);
  assign wrong_inc = (wrong_reg == 4'hF) ? wrong_reg : wrong_reg + 4'd1;

  genvar gi;
  generate
    for (gi = 0; gi < WORD_LEN; gi++) begin : g_slot
      logic [6:0] slot_ch;
      logic [6:0] new_ch;
      assign slot_ch          = word_reg[7*gi +: 7];
      assign new_ch           = bus.word_in[7*gi +: 7];
      assign match_vec[gi]    = (slot_ch != 7'h00) && (slot_ch == guess_reg);
      assign latch_unused[gi] = (new_ch == 7'h00);
      // Unused slots render as spaces regardless of mask or game outcome.
      assign disp_next[7*gi +: 7] = (slot_ch == 7'h00)              ? 7'h20 :
                                    (mask_reg[gi] || show_all)      ? slot_ch :
                                                                      BLANK_CHAR;
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    word_next    = word_reg;
    mask_next    = mask_reg;
    wrong_next   = wrong_reg;
    guessed_next = guessed_reg;
    guess_next   = guess_reg;
    hit_next     = 1'b0;
    miss_next    = 1'b0;
    dup_next     = 1'b0;
    if (bus.restart) begin
      state_next = S_REQ;
    end else begin
      case (state_reg)
        S_IDLE:  state_next = S_IDLE;
        S_REQ:   state_next = S_LATCH;
        S_LATCH: begin
          word_next    = bus.word_in;
          mask_next    = latch_unused;
          wrong_next   = 4'd0;
          guessed_next = 26'd0;
          state_next   = S_PLAY;
        end
        S_PLAY: begin
          if (bus.guess_valid && folded_ok) begin
            guess_next = folded;
            state_next = S_CHECK;
          end
        end
        S_CHECK: begin
          if (guessed_reg[guess_idx]) begin
            dup_next = 1'b1;
`ifdef DUP_PENALTY_EN
            miss_next  = 1'b1;
            wrong_next = wrong_inc;
`endif
          end else begin
            guessed_next[guess_idx] = 1'b1;
            if (|match_vec) begin
              mask_next = mask_reg | match_vec;
              hit_next  = 1'b1;
            end else begin
              miss_next  = 1'b1;
              wrong_next = wrong_inc;
            end
          end
          state_next = S_EVAL;
        end
        S_EVAL: begin
          if (&mask_reg)                     state_next = S_WIN;
          else if (wrong_reg >= MAX_WRONG_C) state_next = S_LOSE;
          else                               state_next = S_PLAY;
        end
        S_WIN:   state_next = S_WIN;
        S_LOSE:  state_next = S_LOSE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      word_reg    <= '0;
      mask_reg    <= '0;
      wrong_reg   <= 4'd0;
      guessed_reg <= 26'd0;
      guess_reg   <= 7'd0;
      hit_reg     <= 1'b0;
      miss_reg    <= 1'b0;
      dup_reg     <= 1'b0;
      disp_reg    <= {WORD_LEN{7'h20}};
    end else begin
      state_reg   <= state_next;
      word_reg    <= word_next;
      mask_reg    <= mask_next;
      wrong_reg   <= wrong_next;
      guessed_reg <= guessed_next;
      guess_reg   <= guess_next;
      hit_reg     <= hit_next;
      miss_reg    <= miss_next;
      dup_reg     <= dup_next;
      disp_reg    <= disp_next;
    end
  end

  assign bus.word_load   = (state_reg == S_REQ);
  assign bus.busy        = (state_reg != S_PLAY);
  assign bus.win         = (state_reg == S_WIN);
  assign bus.lose        = (state_reg == S_LOSE);
  assign bus.disp_word   = disp_reg;
  assign bus.reveal_mask = mask_reg;
  assign bus.wrong_cnt   = wrong_reg;
  assign bus.hit         = hit_reg;
  assign bus.miss        = miss_reg;
  assign bus.dup_guess   = dup_reg;

endmodule
